// File: rtl/core_status_unit_if.sv
// APB3 bus bundle for the core status unit.
// Master drives the request; slave returns data/ready/error.
interface core_status_unit_if #(
  parameter int APB_AW = 12
);
  logic [APB_AW-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/core_status_unit.sv
// Software end-of-computation status word with a freezing
// run-cycle counter and a watchdog that forces a timeout status.
module core_status_unit #(
  parameter int          APB_AW       = 12,
  parameter logic [30:0] TIMEOUT_CODE = 31'h7FFF_FFFE,
  parameter logic [31:0] WDT_DEFAULT  = 32'd0
) (
  input  logic                clk,
  input  logic                reset,
  core_status_unit_if.slave   apb,
  output logic                done_o,
  output logic [30:0]         exit_code_o,
  output logic                wdt_expired_o
);

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CYC_LO = 3'd1;
  localparam logic [2:0] A_CYC_HI = 3'd2;
  localparam logic [2:0] A_WDT_LD = 3'd3;
  localparam logic [2:0] A_WDT_KK = 3'd4;

  logic [31:0] status;
  logic [63:0] cycle;
  logic [31:0] hi_snap;
  logic [31:0] wdt_load;
  logic [31:0] wdt_cnt;
  logic [31:0] prdata;
  logic [31:0] rd_mux;
  logic        wdt_exp;

  logic [APB_AW-1:0] paddr;
  logic [2:0]        sel;
  logic              setup_rd;
  logic              access;
  logic              wr;
  logic              wr_status;
  logic              wr_load;
  logic              wr_kick;
  logic              done;
  logic              bad_addr;
  logic              wdt_run;
  logic              expire;
  logic              sw_done;
  logic              unused_addr;

  assign paddr       = apb.PADDR;
  assign sel         = paddr[4:2];
  assign unused_addr = ^{paddr[APB_AW-1:5], paddr[1:0]};

  assign setup_rd  = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  assign access    = apb.PSEL & apb.PENABLE;
  assign wr        = access & apb.PWRITE;
  assign wr_status = wr & (sel == A_STATUS);
  assign wr_load   = wr & (sel == A_WDT_LD);
  assign wr_kick   = wr & (sel == A_WDT_KK);
  assign done      = status[31];
  assign bad_addr  = sel > A_WDT_KK;

  // A reload in the terminal cycle cancels the expiry.
  assign wdt_run = (wdt_load != 32'd0) & ~done;
  assign expire  = wdt_run & (wdt_cnt == 32'd1)
                 & ~wr_load & ~wr_kick;
  assign sw_done = wr_status & ~done & apb.PWDATA[31];

  assign apb.PREADY  = 1'b1;
  assign apb.PRDATA  = prdata;
  assign apb.PSLVERR = access
                     & (bad_addr
                        | ((sel == A_STATUS) & apb.PWRITE & done));

  assign done_o        = status[31];
  assign exit_code_o   = status[30:0];
  assign wdt_expired_o = wdt_exp;

  // Read data select for the setup-phase capture.
  always_comb begin
    rd_mux = 32'd0;
    unique case (1'b1)
      sel == A_STATUS: rd_mux = status;
      sel == A_CYC_LO: rd_mux = cycle[31:0];
      sel == A_CYC_HI: rd_mux = hi_snap;
      sel == A_WDT_LD: rd_mux = wdt_load;
      default:         rd_mux = 32'd0;
    endcase
  end

  // Status word: software write, lock on bit31, watchdog timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status  <= 32'd0;
      wdt_exp <= 1'b0;
    end else begin
      if (wr_status & ~done & (apb.PWDATA[31] | ~expire))
        status <= apb.PWDATA;
      else if (expire)
        status <= {1'b1, TIMEOUT_CODE};
      if (expire & ~sw_done)
        wdt_exp <= 1'b1;
    end
  end

  // Run-cycle counter, frozen once done is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycle <= 64'd0;
    else if (~done)
      cycle <= cycle + 64'd1;
  end

  // Watchdog reload value and down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_load <= WDT_DEFAULT;
      wdt_cnt  <= WDT_DEFAULT;
    end else if (wr_load) begin
      wdt_load <= apb.PWDATA;
      wdt_cnt  <= apb.PWDATA;
    end else if (wr_kick) begin
      wdt_cnt  <= wdt_load;
    end else if (wdt_run & (wdt_cnt != 32'd0)) begin
      wdt_cnt  <= wdt_cnt - 32'd1;
    end
  end

  // Read data and coherent HI snapshot, captured in setup phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prdata  <= 32'd0;
      hi_snap <= 32'd0;
    end else if (setup_rd) begin
      prdata <= rd_mux;
      if (sel == A_CYC_LO)
        hi_snap <= cycle[63:32];
    end
  end

endmodule

// File: tb/tb_core_status_unit.sv
// Scenario bench for core_status_unit: APB access, status lock,
// cycle counter freeze and watchdog expiry/kick races.
module tb_core_status_unit;

  logic        clk;
  logic        reset;
  logic        done_o;
  logic [30:0] exit_code_o;
  logic        wdt_expired_o;

  int checks;
  int errors;
  int cyc;

  logic [31:0] data_q[$];
  string       name_q[$];

  core_status_unit_if #(.APB_AW(12)) bus ();

  core_status_unit #(
    .APB_AW      (12),
    .TIMEOUT_CODE(31'h7FFF_FFFE),
    .WDT_DEFAULT (32'd0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .apb          (bus.slave),
    .done_o       (done_o),
    .exit_code_o  (exit_code_o),
    .wdt_expired_o(wdt_expired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 12'h0;
    bus.PWDATA  = 32'h0;
  endtask

  task automatic apb_write(input logic [11:0] a,
                           input logic [31:0] d,
                           output logic err);
    @(negedge clk);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    #1;
    err = bus.PSLVERR;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic apb_read(input logic [11:0] a,
                          output logic [31:0] d,
                          output logic err,
                          output int t);
    @(negedge clk);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = a;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    t = cyc;
    #1;
    d   = bus.PRDATA;
    err = bus.PSLVERR;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] ed;
    logic        er;
    string       nm;
    int          t1;
    int          t2;
    logic [31:0] v1;
    // abort a STATUS write in its access phase
    @(negedge clk);
    bus.PSEL    = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = 12'h000;
    bus.PWDATA  = 32'h8000_0007;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.PREADY !== 1'b1 || bus.PRDATA !== 32'h0) begin
      errors++;
      $display("FAIL rst_bus pready=%b prdata=%h want 1/0",
               bus.PREADY, bus.PRDATA);
    end
    repeat (2) @(negedge clk);
    bus_idle();
    #1;
    checks++;
    if (done_o !== 1'b0 || exit_code_o !== 31'h0 ||
        wdt_expired_o !== 1'b0 || bus.PSLVERR !== 1'b0) begin
      errors++;
      $display("FAIL rst_out done=%b code=%h wdt=%b err=%b want 0",
               done_o, exit_code_o, wdt_expired_o, bus.PSLVERR);
    end
    reset = 1'b0;
    data_q.push_back(32'h0);
    name_q.push_back("rst_status");
    apb_read(12'h000, rd, er, t1);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed || er !== 1'b0) begin
      errors++;
      $display("FAIL %s got %h err %b want %h err 0", nm, rd, er, ed);
    end
    apb_read(12'h004, v1, er, t1);
    repeat (5) @(posedge clk);
    apb_read(12'h004, rd, er, t2);
    data_q.push_back(v1 + 32'(t2 - t1));
    name_q.push_back("cyc_delta");
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rd, ed);
    end
    data_q.push_back(32'h0);
    name_q.push_back("cyc_hi");
    apb_read(12'h008, rd, er, t1);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rd, ed);
    end
  endtask

  task automatic test_status_lock();
    logic [31:0] rd;
    logic [31:0] ed;
    logic [31:0] v1;
    logic        er;
    string       nm;
    int          t;
    do_reset();
    apb_write(12'h000, 32'h0000_0005, er);
    data_q.push_back(32'h0000_0005);
    name_q.push_back("status_5");
    apb_read(12'h000, rd, er, t);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rd, ed);
    end
    apb_write(12'h000, 32'h8000_0000, er);
    checks++;
    if (done_o !== 1'b1 || exit_code_o !== 31'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL set_done done=%b code=%h err=%b want 1/0/0",
               done_o, exit_code_o, er);
    end
    apb_read(12'h004, v1, er, t);
    repeat (3) @(posedge clk);
    data_q.push_back(v1);
    name_q.push_back("cyc_frozen");
    apb_read(12'h004, rd, er, t);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rd, ed);
    end
    apb_write(12'h000, 32'h8000_0003, er);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL lock_err got %b want 1", er);
    end
    data_q.push_back(32'h8000_0000);
    name_q.push_back("lock_status");
    apb_read(12'h000, rd, er, t);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rd, ed);
    end
    // asynchronous clear: check before any clock edge
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL async_rst done=%b want 0", done_o);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wdt_expiry();
    logic [31:0] rd;
    logic [31:0] ed;
    logic        er;
    string       nm;
    int          t;
    int          n;
    do_reset();
    apb_write(12'h00C, 32'd10, er);
    n = 0;
    while (!done_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 10 || wdt_expired_o !== 1'b1) begin
      errors++;
      $display("FAIL wdt_time got %0d cycles wdt=%b want 10/1",
               n, wdt_expired_o);
    end
    data_q.push_back(32'hFFFF_FFFE);
    name_q.push_back("wdt_status");
    data_q.push_back(32'd10);
    name_q.push_back("wdt_load_rd");
    apb_read(12'h000, rd, er, t);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rd, ed);
    end
    apb_read(12'h00C, rd, er, t);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, rd, ed);
    end
  endtask

  task automatic test_wdt_kick();
    logic er;
    int   n;
    do_reset();
    apb_write(12'h00C, 32'd10, er);
    for (int k = 0; k < 12; k++) begin
      repeat (6) @(posedge clk);
      apb_write(12'h010, 32'h0, er);
    end
    checks++;
    if (done_o !== 1'b0 || wdt_expired_o !== 1'b0) begin
      errors++;
      $display("FAIL kick_hold done=%b wdt=%b want 0/0",
               done_o, wdt_expired_o);
    end
    n = 0;
    while (!done_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 10 || wdt_expired_o !== 1'b1) begin
      errors++;
      $display("FAIL kick_stop got %0d cycles wdt=%b want 10/1",
               n, wdt_expired_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] ed;
    logic        er;
    string       nm;
    int          t;
    // kick lands on the counter=1 cycle
    do_reset();
    apb_write(12'h00C, 32'd10, er);
    repeat (8) @(posedge clk);
    apb_write(12'h010, 32'h0, er);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || wdt_expired_o !== 1'b0) begin
      errors++;
      $display("FAIL kick_race done=%b wdt=%b want 0/0",
               done_o, wdt_expired_o);
    end
    // software done lands on the expiry cycle
    do_reset();
    apb_write(12'h00C, 32'd10, er);
    repeat (8) @(posedge clk);
    apb_write(12'h000, 32'h8000_0000, er);
    data_q.push_back(32'h8000_0000);
    name_q.push_back("sw_race");
    apb_read(12'h000, rd, er, t);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed || wdt_expired_o !== 1'b0) begin
      errors++;
      $display("FAIL %s got %h wdt %b want %h wdt 0",
               nm, rd, wdt_expired_o, ed);
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] rd;
    logic [31:0] ed;
    logic        er;
    string       nm;
    int          t;
    do_reset();
    apb_write(12'h018, 32'hDEAD_BEEF, er);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL bad_wr_err got %b want 1", er);
    end
    data_q.push_back(32'h0);
    name_q.push_back("bad_rd");
    apb_read(12'h018, rd, er, t);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed || er !== 1'b1) begin
      errors++;
      $display("FAIL %s got %h err %b want %h err 1", nm, rd, er, ed);
    end
    apb_write(12'h00C, 32'd500, er);
    data_q.push_back(32'h0);
    name_q.push_back("kick_rd");
    apb_read(12'h010, rd, er, t);
    ed = data_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    if (rd !== ed || er !== 1'b0) begin
      errors++;
      $display("FAIL %s got %h err %b want %h err 0", nm, rd, er, ed);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b0;
    bus_idle();
    test_reset();
    test_status_lock();
    test_wdt_expiry();
    test_wdt_kick();
    test_back_to_back();
    test_bad_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
